// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: walks the fetch PC, issues requests to a 1-cycle
// synchronous instruction memory, buffers returned words in a small prefetch
// FIFO and presents the head to IF/ID with a valid/stall handshake.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    INST_WIDTH = 16,
    parameter int                    BUF_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt,
    output logic [INST_WIDTH-1:0] if_id_inst_out,
    output logic [ADDR_WIDTH-1:0] if_id_pc_out,
    output logic                  if_id_valid
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;

    entry_t                fifo_q [BUF_DEPTH];
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q;

    logic                  pop;
    logic                  push;
    logic                  flush;
    logic [OCC_W-1:0]      occ;
    entry_t                head_entry;

    // Head of the FIFO drives IF/ID directly; NOP and PC 0 when empty.
    assign if_id_valid    = (count_q != '0);
    assign head_entry     = fifo_q[head_q];
    assign if_id_inst_out = if_id_valid ? head_entry.inst : '0;
    assign if_id_pc_out   = if_id_valid ? head_entry.pc   : '0;
    assign imem_addr      = fetch_pc_q;

    assign pop  = if_id_valid & ~stall;
    // Credit count: entries held plus the word on its way back, less the one
    // leaving this cycle. A request is only made if its data has a slot.
    assign occ  = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    // A redirect discards the returning word; halted state still accepts it.
    assign push = inflight_q & ~flush;

    // Next-state and request decode; branch beats halt beats normal fetch.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        flush    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (branch_taken) begin
                    flush = 1'b1;
                end else if (halt) begin
                    state_d = HALTED;
                end else begin
                    imem_req = (occ < OCC_W'(BUF_DEPTH));
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, fetch PC, in-flight tracking and FIFO pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                fetch_pc_q <= branch_target;
                inflight_q <= 1'b0;
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
            end else begin
                inflight_q <= imem_req;
                if (imem_req) begin
                    inflight_pc_q <= fetch_pc_q;
                    fetch_pc_q    <= fetch_pc_q + ADDR_WIDTH'(1);
                end
                if (push) tail_q <= tail_q + PTR_W'(1);
                if (pop)  head_q <= head_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // FIFO storage; contents are never observed while count is zero.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[tail_q] <= '{pc: inflight_pc_q, inst: imem_rdata};
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one instance with RESET_PC=0 and one with
// RESET_PC=8'hFE sharing control inputs; each has a memory returning addr as data.
module tb_if_fetch_unit;

    localparam int AW = 8;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic          halt = 1'b0;

    logic          req0, req1;
    logic [AW-1:0] addr0, addr1;
    logic [IW-1:0] rdata0, rdata1;
    logic [IW-1:0] inst0, inst1;
    logic [AW-1:0] pc0, pc1;
    logic          vld0, vld1;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    if_fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .BUF_DEPTH(2), .RESET_PC(8'h00)) dut0 (
        .clock(clock), .reset(reset), .imem_req(req0), .imem_addr(addr0),
        .imem_rdata(rdata0), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .if_id_inst_out(inst0),
        .if_id_pc_out(pc0), .if_id_valid(vld0)
    );

    if_fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .BUF_DEPTH(2), .RESET_PC(8'hFE)) dut1 (
        .clock(clock), .reset(reset), .imem_req(req1), .imem_addr(addr1),
        .imem_rdata(rdata1), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .if_id_inst_out(inst1),
        .if_id_pc_out(pc1), .if_id_valid(vld1)
    );

    // Synchronous memory: word i lives at address i, one cycle of latency.
    always @(posedge clock) begin
        rdata0 <= IW'(addr0);
        rdata1 <= IW'(addr1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic head0(input string tag, input logic [AW-1:0] pc);
        chk({tag, ".valid"}, 32'(vld0), 32'd1);
        chk({tag, ".pc"}, 32'(pc0), 32'(pc));
        chk({tag, ".inst"}, 32'(inst0), 32'(pc));
    endtask

    task automatic empty0(input string tag);
        chk({tag, ".valid"}, 32'(vld0), 32'd0);
        chk({tag, ".pc"}, 32'(pc0), 32'd0);
        chk({tag, ".inst"}, 32'(inst0), 32'd0);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        #1;
        empty0("rst");
        chk("rst.req", 32'(req0), 32'd0);
        chk("rst.addr0", 32'(addr0), 32'h00);
        chk("rst.addr1", 32'(addr1), 32'hFE);

        // Release: IDLE cycle, then first request
        tick(); reset = 1'b1; #1;
        chk("idle.req", 32'(req0), 32'd0);
        empty0("idle");
        tick(); #1;
        chk("c1.req", 32'(req0), 32'd1);
        chk("c1.addr", 32'(addr0), 32'h00);
        chk("c1.addr1", 32'(addr1), 32'hFE);
        tick(); #1;
        chk("c2.req", 32'(req0), 32'd1);
        chk("c2.addr", 32'(addr0), 32'h01);
        chk("c2.valid", 32'(vld0), 32'd0);
        tick(); #1;
        head0("c3", 8'h00);
        chk("c3.addr", 32'(addr0), 32'h02);
        chk("wrap.pc_fe", 32'(pc1), 32'hFE);
        chk("wrap.inst_fe", 32'(inst1), 32'h00FE);
        tick(); #1;
        head0("c4", 8'h01);
        chk("wrap.pc_ff", 32'(pc1), 32'hFF);
        tick(); #1;
        head0("c5", 8'h02);
        chk("wrap.pc_00", 32'(pc1), 32'h00);
        chk("wrap.valid_00", 32'(vld1), 32'd1);

        // Stall held 4 cycles on pc 3
        for (int i = 0; i < 4; i++) begin
            tick(); stall = 1'b1; #1;
            head0("stall.hold", 8'h03);
            chk("stall.req", 32'(req0), 32'd0);
        end
        tick(); stall = 1'b0; #1;
        head0("unstall.pc3", 8'h03);
        chk("unstall.req", 32'(req0), 32'd1);
        chk("unstall.addr", 32'(addr0), 32'h05);
        tick(); #1;
        head0("unstall.pc4", 8'h04);

        // Branch to 0x40 while pc 5 is buffered and pc 6 in flight
        tick(); branch_taken = 1'b1; branch_target = 8'h40; #1;
        head0("br.pre", 8'h05);
        chk("br.req", 32'(req0), 32'd0);
        tick(); branch_taken = 1'b0; #1;
        empty0("br.flush");
        chk("br.req_next", 32'(req0), 32'd1);
        chk("br.addr_next", 32'(addr0), 32'h40);
        tick(); #1;
        empty0("br.wait");
        chk("br.addr2", 32'(addr0), 32'h41);
        tick(); #1;
        head0("br.first", 8'h40);

        // Branch together with stall, buffer full (0x41,0x42)
        tick(); stall = 1'b1; #1;
        head0("brst.fill", 8'h41);
        chk("brst.req_fill", 32'(req0), 32'd0);
        tick(); branch_taken = 1'b1; branch_target = 8'h0A; #1;
        head0("brst.pre", 8'h41);
        chk("brst.req", 32'(req0), 32'd0);
        tick(); branch_taken = 1'b0; stall = 1'b0; #1;
        empty0("brst.flush");
        chk("brst.req_next", 32'(req0), 32'd1);
        chk("brst.addr_next", 32'(addr0), 32'h0A);
        tick(); #1;
        empty0("brst.wait");
        chk("brst.addr2", 32'(addr0), 32'h0B);

        // Halt with head pc 10: no requests, buffer drains
        tick(); halt = 1'b1; #1;
        head0("halt.pc10", 8'h0A);
        chk("halt.req", 32'(req0), 32'd0);
        tick(); #1;
        head0("halt.drain", 8'h0B);
        chk("halt.req2", 32'(req0), 32'd0);
        tick(); halt = 1'b0; #1;
        empty0("halt.empty");
        chk("halt.sticky_req", 32'(req0), 32'd0);
        tick(); branch_taken = 1'b1; branch_target = 8'h33; #1;
        chk("halt.br_req", 32'(req0), 32'd0);
        tick(); branch_taken = 1'b0; #1;
        chk("halt.br_ignored_addr", 32'(addr0), 32'h0C);
        chk("halt.br_ignored_req", 32'(req0), 32'd0);
        empty0("halt.br_ignored");

        // Reset from halted, then restart
        #2; reset = 1'b0; #1;
        empty0("rst2");
        chk("rst2.addr", 32'(addr0), 32'h00);
        tick(); reset = 1'b1; #1;
        chk("rst2.idle_req", 32'(req0), 32'd0);
        tick(); #1;
        chk("rst2.req", 32'(req0), 32'd1);
        chk("rst2.addr0", 32'(addr0), 32'h00);
        tick(); #1;
        chk("rst2.valid_lat", 32'(vld0), 32'd0);
        tick(); #1;
        head0("rst2.pc0", 8'h00);
        tick(); #1;
        head0("rst2.pc1", 8'h01);

        // Asynchronous reset in the middle of a cycle, mid-stream
        #2; reset = 1'b0; #1;
        empty0("rst3.async");
        chk("rst3.req", 32'(req0), 32'd0);
        chk("rst3.addr", 32'(addr0), 32'h00);
        chk("rst3.addr1", 32'(addr1), 32'hFE);
        tick(); reset = 1'b1; #1;
        chk("rst3.idle_req", 32'(req0), 32'd0);
        empty0("rst3.idle");
        tick(); #1;
        chk("rst3.req", 32'(req0), 32'd1);
        chk("rst3.addr0", 32'(addr0), 32'h00);
        tick(); #1;
        empty0("rst3.lat");
        tick(); #1;
        head0("rst3.pc0", 8'h00);
        chk("rst3.pc1_fe", 32'(pc1), 32'hFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
